// File: rtl/eth_phy_10g_rx_frame_sync.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_rx_frame_sync
//
// 10GBASE-R receive block-lock state machine. Each 66b block's sync header is
// sampled once per clock. While hunting for alignment, the block asks the
// gearbox to slip one bit position whenever an invalid header is seen. Lock is
// declared after 64 consecutive valid headers. Once locked, lock is kept until
// 16 invalid headers occur inside one 64-header window.
//
// Ports:
//   clk               receive clock, one sync header per cycle
//   rst               asynchronous, active-high reset
//   serdes_rx_hdr     sync header of the current block (01 = ctrl, 10 = data)
//   serdes_rx_bitslip bitslip request to the gearbox/SERDES (registered)
//   rx_block_lock     block lock indication (registered)
// -----------------------------------------------------------------------------
module eth_phy_10g_rx_frame_sync #(
  parameter int HDR_WIDTH           = 2,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  output logic                 serdes_rx_bitslip,
  output logic                 rx_block_lock
);

  // Parameter legality is checked while elaborating so a bad build never
  // reaches synthesis.
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $fatal(1, "HDR_WIDTH must be 2");
  end
  if (BITSLIP_HIGH_CYCLES < 1 || BITSLIP_HIGH_CYCLES > 255) begin : g_bad_high
    $fatal(1, "BITSLIP_HIGH_CYCLES must be 1..255");
  end
  if (BITSLIP_LOW_CYCLES < 0 || BITSLIP_LOW_CYCLES > 255) begin : g_bad_low
    $fatal(1, "BITSLIP_LOW_CYCLES must be 0..255");
  end

  localparam logic [7:0] SLIP_HIGH_INIT = 8'(BITSLIP_HIGH_CYCLES - 1);
  // Unused when BITSLIP_LOW_CYCLES is 0 (SLIP_LOW is skipped entirely).
  localparam logic [7:0] SLIP_LOW_INIT  = 8'(BITSLIP_LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    LOCKED    = 2'd1,
    SLIP_HIGH = 2'd2,
    SLIP_LOW  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [5:0] sh_count_reg, sh_count_next;
  logic [3:0] sh_invalid_count_reg, sh_invalid_count_next;
  logic [7:0] slip_count_reg, slip_count_next;
  logic       lock_reg, lock_next;
  logic       bitslip_reg, bitslip_next;

  // 01 and 10 are the only legal sync headers: exactly the two-bit values
  // whose bits differ.
  logic hdr_valid;
  assign hdr_valid = ^serdes_rx_hdr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg            <= HUNT;
      sh_count_reg         <= '0;
      sh_invalid_count_reg <= '0;
      slip_count_reg       <= '0;
      lock_reg             <= 1'b0;
      bitslip_reg          <= 1'b0;
    end else begin
      state_reg            <= state_next;
      sh_count_reg         <= sh_count_next;
      sh_invalid_count_reg <= sh_invalid_count_next;
      slip_count_reg       <= slip_count_next;
      lock_reg             <= lock_next;
      bitslip_reg          <= bitslip_next;
    end
  end

  always_comb begin
    state_next            = state_reg;
    sh_count_next         = sh_count_reg;
    sh_invalid_count_next = sh_invalid_count_reg;
    slip_count_next       = slip_count_reg;
    lock_next             = lock_reg;
    bitslip_next          = bitslip_reg;

    case (state_reg)
      HUNT: begin
        if (hdr_valid) begin
          if (sh_count_reg == 6'd63) begin
            state_next    = LOCKED;
            lock_next     = 1'b1;
            sh_count_next = '0;
          end else begin
            sh_count_next = sh_count_reg + 6'd1;
          end
        end else begin
          state_next            = SLIP_HIGH;
          sh_count_next         = '0;
          sh_invalid_count_next = '0;
          bitslip_next          = 1'b1;
          slip_count_next       = SLIP_HIGH_INIT;
        end
      end

      LOCKED: begin
        // The 16th invalid header in a window wins over the window ending.
        if (!hdr_valid && sh_invalid_count_reg == 4'd15) begin
          state_next            = SLIP_HIGH;
          lock_next             = 1'b0;
          sh_count_next         = '0;
          sh_invalid_count_next = '0;
          bitslip_next          = 1'b1;
          slip_count_next       = SLIP_HIGH_INIT;
        end else if (sh_count_reg == 6'd63) begin
          sh_count_next         = '0;
          sh_invalid_count_next = '0;
        end else begin
          sh_count_next         = sh_count_reg + 6'd1;
          sh_invalid_count_next = sh_invalid_count_reg + {3'b000, ~hdr_valid};
        end
      end

      SLIP_HIGH: begin
        if (slip_count_reg == 8'd0) begin
          bitslip_next = 1'b0;
          if (BITSLIP_LOW_CYCLES == 0) begin
            state_next = HUNT;
          end else begin
            state_next      = SLIP_LOW;
            slip_count_next = SLIP_LOW_INIT;
          end
        end else begin
          slip_count_next = slip_count_reg - 8'd1;
        end
      end

      SLIP_LOW: begin
        if (slip_count_reg == 8'd0) begin
          state_next = HUNT;
        end else begin
          slip_count_next = slip_count_reg - 8'd1;
        end
      end

      default: begin
        state_next = HUNT;
      end
    endcase
  end

  assign serdes_rx_bitslip = bitslip_reg;
  assign rx_block_lock     = lock_reg;

endmodule

// File: tb/tb_eth_phy_10g_rx_frame_sync.sv
// -----------------------------------------------------------------------------
// Testbench for eth_phy_10g_rx_frame_sync (default parameters 2 / 1 / 8).
// Directed sequences, a vector table for the free-running slip cadence, and a
// long randomized run compared cycle by cycle with a behavioural model.
// -----------------------------------------------------------------------------
module tb_eth_phy_10g_rx_frame_sync;

  localparam int H = 1;   // bitslip high cycles
  localparam int L = 8;   // bitslip low (settling) cycles
  localparam int NVEC = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] serdes_rx_hdr = 2'b10;
  logic       serdes_rx_bitslip;
  logic       rx_block_lock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counts consecutive valid headers while hunting, counts
  // window position / bad headers while locked, and treats a slip as one
  // stretch of H+L ignored headers of which the first H show bitslip high.
  int m_run, m_pos, m_bad, m_ignore;
  bit m_lock;

  typedef struct {
    logic [1:0] hdr;
    logic       exp_lock;
    logic       exp_slip;
  } vec_t;
  vec_t vecs [NVEC];

  eth_phy_10g_rx_frame_sync #(
    .HDR_WIDTH(2),
    .BITSLIP_HIGH_CYCLES(H),
    .BITSLIP_LOW_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .serdes_rx_hdr(serdes_rx_hdr),
    .serdes_rx_bitslip(serdes_rx_bitslip),
    .rx_block_lock(rx_block_lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_bad = 0; m_ignore = 0; m_lock = 0;
  endtask

  task automatic model_update(input logic [1:0] h);
    bit valid;
    valid = (h == 2'b01) || (h == 2'b10);
    if (m_ignore > 0) begin
      m_ignore--;
    end else if (!m_lock) begin
      if (valid) begin
        m_run++;
        if (m_run == 64) begin
          m_lock = 1; m_run = 0; m_pos = 0; m_bad = 0;
        end
      end else begin
        m_run = 0;
        m_ignore = H + L;
      end
    end else begin
      m_pos++;
      if (!valid) m_bad++;
      if (m_bad == 16) begin
        m_lock = 0; m_pos = 0; m_bad = 0; m_ignore = H + L;
      end else if (m_pos == 64) begin
        m_pos = 0; m_bad = 0;
      end
    end
  endtask

  // Present one header, clock it in, sample outputs 1 time unit later.
  task automatic clock_in(input logic [1:0] h);
    serdes_rx_hdr = h;
    @(posedge clk);
    #1;
    model_update(h);
  endtask

  task automatic step(input logic [1:0] h, input string tag);
    clock_in(h);
    check({tag, "_lock"}, rx_block_lock, m_lock);
    check({tag, "_slip"}, serdes_rx_bitslip, (m_ignore > L));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    serdes_rx_hdr = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] rand_valid();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rand_invalid();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  initial begin
    // Continuous invalid input from reset: slip after headers 0, 10, 20.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].hdr      = 2'b00;
      vecs[i].exp_lock = 1'b0;
      vecs[i].exp_slip = ((i % (H + L + 1)) == 0);
    end

    model_reset();
    do_reset();
    check("reset_lock", rx_block_lock, 1'b0);
    check("reset_slip", serdes_rx_bitslip, 1'b0);

    // 64 data headers -> lock the cycle after the 64th.
    for (int i = 0; i < 64; i++) begin
      step(2'b10, "lock64");
      if (i == 62) check("lock_after_63", rx_block_lock, 1'b0);
      if (i == 63) check("lock_after_64", rx_block_lock, 1'b1);
    end
    $display("txn lock64 done: lock=%0b slip=%0b", rx_block_lock, serdes_rx_bitslip);

    // Locked window with 15 invalid headers keeps lock.
    for (int i = 0; i < 64; i++) step((i < 15) ? 2'b11 : 2'b01, "win15");
    check("win15_held", rx_block_lock, 1'b1);
    $display("txn window-15-bad done: lock=%0b", rx_block_lock);

    // Next window restarts counting: 16 invalid at positions 0..15 unlocks.
    for (int i = 0; i < 16; i++) begin
      step(2'b11, "win16");
      if (i == 14) check("win16_still_locked", rx_block_lock, 1'b1);
    end
    check("win16_unlock", rx_block_lock, 1'b0);
    check("win16_slip", serdes_rx_bitslip, 1'b1);
    $display("txn window-16-bad done: lock=%0b slip=%0b", rx_block_lock, serdes_rx_bitslip);

    // Vector table: free-running slip cadence on constant 00.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      clock_in(vecs[i].hdr);
      check($sformatf("vec%0d_lock", i), rx_block_lock, vecs[i].exp_lock);
      check($sformatf("vec%0d_slip", i), serdes_rx_bitslip, vecs[i].exp_slip);
    end
    $display("txn slip-cadence table done: %0d vectors", NVEC);

    // HUNT: 30 valid, one invalid, H+L ignored headers, then a fresh 64.
    do_reset();
    for (int i = 0; i < 30; i++) step(rand_valid(), "hunt30");
    step(2'b00, "hunt_bad");
    check("hunt_bad_slip", serdes_rx_bitslip, 1'b1);
    for (int i = 0; i < H + L; i++) begin
      step($urandom_range(0, 3), "ignored");
      check("ignored_slip_low", serdes_rx_bitslip, 1'b0);
    end
    for (int i = 0; i < 64; i++) begin
      step(rand_valid(), "relock");
      if (i == 62) check("relock_after_63", rx_block_lock, 1'b0);
      if (i == 63) check("relock_after_64", rx_block_lock, 1'b1);
    end
    $display("txn hunt-restart done: lock=%0b", rx_block_lock);

    // Async reset while locked drops lock without a clock edge.
    #3 rst = 1'b1;
    #1;
    check("async_rst_lock", rx_block_lock, 1'b0);
    do_reset();

    // Async reset in SLIP_HIGH drops bitslip without a clock edge.
    step(2'b00, "enter_slip");
    check("enter_slip_high", serdes_rx_bitslip, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_slip", serdes_rx_bitslip, 1'b0);
    check("async_rst_slip_lock", rx_block_lock, 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(2'b10, "post_rst");
      if (i == 62) check("post_rst_after_63", rx_block_lock, 1'b0);
      if (i == 63) check("post_rst_after_64", rx_block_lock, 1'b1);
    end
    $display("txn async-reset done: lock=%0b slip=%0b", rx_block_lock, serdes_rx_bitslip);

    // Randomized run with segments of varying error density.
    do_reset();
    for (int seg = 0; seg < 30; seg++) begin
      int rate;
      case (seg % 4)
        0: rate = 0;
        1: rate = 2;
        2: rate = 20;
        default: rate = 40;
      endcase
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < rate) step(rand_invalid(), "rand");
        else step(rand_valid(), "rand");
      end
      $display("txn random segment %0d (err %0d%%): lock=%0b", seg, rate, rx_block_lock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
